// File: rtl/deser_sched_pkg.sv
// Shared types and helpers for the deserializer frame scheduler.
package deser_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Output settle delay after the active clock edge, used for sampling.
  localparam int TCO = 1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deser_frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past the last grant.
module rr_arbiter
  import deser_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_gnt,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IW-1:0]      gnt_idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_gnt) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/deser_frame_sched.sv
// Streams one PARL_WIDTH-sample frame per grant from NUM_REQ sources into a shared
// Deserializer. Optional abort-on-underrun: define DESER_SCHED_UNDERRUN_EN.
module deser_frame_sched
  import deser_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARL_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_dir,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fft_ready,
  output logic                          des_en,
  output logic                          des_dir,
  output logic [DATA_WIDTH-1:0]         des_ser,
  input  logic                          des_valid,
  output logic                          frm_valid,
  output logic [$clog2(NUM_REQ)-1:0]    frm_id,
  input  logic                          err_clr,
  output logic                          err_underrun,
  output state_t                        fsm_state
);

  localparam int IW = id_width(NUM_REQ);
  localparam int CW = $clog2(PARL_WIDTH);

  state_t               state_q, state_d;
  logic [IW-1:0]        gnt_q, last_gnt_q, arb_idx;
  logic [NUM_REQ-1:0]   gnt_oh_q, arb_oh;
  logic [CW-1:0]        beat_q;
  logic                 dir_q;
  logic                 grant, beat_inc, last_beat, sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .gnt_oh   (arb_oh),
    .gnt_idx  (arb_idx)
  );

  assign sel_valid = req_valid[gnt_q];
  assign sel_data  = req_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign last_beat = (beat_q == CW'(PARL_WIDTH - 1));
  assign des_dir   = dir_q;
  assign fsm_state = state_q;

`ifdef DESER_SCHED_UNDERRUN_EN
  logic underrun, err_q;
`endif

  // Handshake: a sample transfers in a cycle where req_valid and req_ready are
  // both high; req_ready is only raised for the granted source during BURST.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    des_en    = 1'b0;
    des_ser   = '0;
    frm_valid = 1'b0;
    frm_id    = '0;
    grant     = 1'b0;
    beat_inc  = 1'b0;
`ifdef DESER_SCHED_UNDERRUN_EN
    underrun  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fft_ready && (|req_valid)) begin
          grant   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready = gnt_oh_q;
`ifdef DESER_SCHED_UNDERRUN_EN
        des_en  = sel_valid;
        des_ser = sel_data;
        if (sel_valid) begin
          beat_inc = 1'b1;
          if (last_beat) state_d = DONE;
        end else begin
          underrun = 1'b1;
          state_d  = IDLE;
        end
`else
        // A starving source is zero-padded so the frame still completes.
        des_en   = 1'b1;
        des_ser  = sel_valid ? sel_data : '0;
        beat_inc = 1'b1;
        if (last_beat) state_d = DONE;
`endif
      end
      DONE: begin
        frm_valid = des_valid;
        frm_id    = gnt_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      last_gnt_q <= IW'(NUM_REQ - 1);
      dir_q      <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_q      <= arb_idx;
        gnt_oh_q   <= arb_oh;
        last_gnt_q <= arb_idx;
        dir_q      <= req_dir[arb_idx];
      end
      if (beat_inc) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      else if (state_d != BURST) beat_q <= '0;
    end
  end

`ifdef DESER_SCHED_UNDERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_q <= 1'b0;
    else if (underrun) err_q <= 1'b1;
    else if (err_clr)  err_q <= 1'b0;
  end
  assign err_underrun = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_underrun   = 1'b0;
`endif

endmodule

// File: tb/tb_deser_frame_sched.sv
// Directed bench for deser_frame_sched with a behavioural Deserializer model.
module tb_deser_frame_sched;
  import deser_sched_pkg::*;

  localparam int W = 8;
  localparam int P = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_dir   = 4'b1010;
  logic [N-1:0]   req_ready;
  logic           fft_ready = 1'b0;
  logic           des_en, des_dir;
  logic [W-1:0]   des_ser;
  logic           des_valid;
  logic           frm_valid;
  logic [1:0]     frm_id;
  logic           err_clr = 1'b0;
  logic           err_underrun;
  state_t         fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deser_frame_sched #(.DATA_WIDTH(W), .PARL_WIDTH(P), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_dir(req_dir), .req_ready(req_ready), .fft_ready(fft_ready),
    .des_en(des_en), .des_dir(des_dir), .des_ser(des_ser),
    .des_valid(des_valid), .frm_valid(frm_valid), .frm_id(frm_id),
    .err_clr(err_clr), .err_underrun(err_underrun), .fsm_state(fsm_state)
  );

  // Deserializer model: count restarts whenever en is low; valid one cycle after beat P-1.
  logic [W-1:0] par [P];
  int           dcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt      <= 0;
      des_valid <= 1'b0;
    end else begin
      des_valid <= 1'b0;
      if (des_en) begin
        par[dcnt] <= des_ser;
        if (dcnt == P - 1) begin
          dcnt      <= 0;
          des_valid <= 1'b1;
        end else begin
          dcnt <= dcnt + 1;
        end
      end else begin
        dcnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #TCO;
  endtask

  // Entered post-edge in IDLE with src the expected round-robin winner.
  task automatic frame(input int src, input logic [7:0] base, input int drop_at,
                       input int fft_drop_at);
    logic       exp_dir;
    logic [7:0] exp_ser;
    logic [7:0] exp_par [P];
    exp_dir = req_dir[src];
    step();
    for (int k = 0; k < P; k++) begin
      if (k == drop_at) req_valid[src] = 1'b0;
      if (k == fft_drop_at) fft_ready = 1'b0;
      req_data[src*W +: W] = base + 8'(k);
      #TCO;
`ifdef DESER_SCHED_UNDERRUN_EN
      if (drop_at >= 0 && k >= drop_at) begin
        chk("underrun_des_en", 32'(des_en), 32'd0);
        step();
        chk("underrun_err", 32'(err_underrun), 32'd1);
        chk("underrun_no_frm", 32'(frm_valid), 32'd0);
        chk("underrun_idle", 32'(fsm_state), 32'(IDLE));
        return;
      end
`endif
      exp_ser    = (drop_at >= 0 && k >= drop_at) ? 8'h00 : base + 8'(k);
      exp_par[k] = exp_ser;
      chk("burst_des_en", 32'(des_en), 32'd1);
      chk("burst_des_ser", 32'(des_ser), 32'(exp_ser));
      chk("burst_req_ready", 32'(req_ready), 32'(1 << src));
      chk("burst_no_frm", 32'(frm_valid), 32'd0);
      if (k == 0) chk("burst_des_dir", 32'(des_dir), 32'(exp_dir));
      step();
    end
    chk("done_des_en", 32'(des_en), 32'd0);
    chk("done_frm_valid", 32'(frm_valid), 32'd1);
    chk("done_frm_id", 32'(frm_id), 32'(src));
    chk("done_req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < P; k++) chk("done_sample", 32'(par[k]), 32'(exp_par[k]));
    step();
    chk("gap_des_en", 32'(des_en), 32'd0);
    chk("gap_frm_valid", 32'(frm_valid), 32'd0);
    chk("gap_frm_id", 32'(frm_id), 32'd0);
  endtask

  initial begin
    // Reset values
    #TCO;
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_des_en", 32'(des_en), 32'd0);
    chk("rst_des_dir", 32'(des_dir), 32'd0);
    chk("rst_des_ser", 32'(des_ser), 32'd0);
    chk("rst_frm_valid", 32'(frm_valid), 32'd0);
    chk("rst_frm_id", 32'(frm_id), 32'd0);
    chk("rst_err", 32'(err_underrun), 32'd0);
    step();
    rst = 1'b0;

    // Single source, back-to-back frames at the 10-cycle period
    req_valid = 4'b0001;
    fft_ready = 1'b1;
    frame(0, 8'h10, -1, -1);
    frame(0, 8'h20, -1, -1);
    req_valid = '0;

    // Fresh reset, then all four requesting: 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    frame(0, 8'h30, -1, -1);
    frame(1, 8'h38, -1, -1);
    frame(2, 8'h40, -1, -1);
    frame(3, 8'h48, -1, -1);
    frame(0, 8'h50, -1, -1);

    // fft_ready low blocks grants
    fft_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nofft_des_en", 32'(des_en), 32'd0);
      chk("nofft_req_ready", 32'(req_ready), 32'd0);
      chk("nofft_state", 32'(fsm_state), 32'(IDLE));
    end
    // fft_ready dropping in beat 3 does not disturb the frame in flight
    fft_ready = 1'b1;
    frame(1, 8'h60, -1, 3);
    step();
    chk("nofft_after_des_en", 32'(des_en), 32'd0);
    fft_ready = 1'b1;

    // Source 2 starves from beat 5
    req_valid = 4'b0100;
    frame(2, 8'h70, 5, -1);
    req_valid = 4'b1111;
    frame(3, 8'h80, -1, -1);
`ifdef DESER_SCHED_UNDERRUN_EN
    chk("err_sticky", 32'(err_underrun), 32'd1);
`else
    chk("err_tied_low", 32'(err_underrun), 32'd0);
`endif
    fft_ready = 1'b0;
    err_clr   = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_underrun), 32'd0);

    // Asynchronous reset in BURST beat 4
    fft_ready = 1'b1;
    req_valid = 4'b0010;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_des_en", 32'(des_en), 32'd1);
    #2;
    rst = 1'b1;
    #TCO;
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_des_en", 32'(des_en), 32'd0);
    chk("arst_des_ser", 32'(des_ser), 32'd0);
    chk("arst_des_dir", 32'(des_dir), 32'd0);
    chk("arst_frm_valid", 32'(frm_valid), 32'd0);
    chk("arst_frm_id", 32'(frm_id), 32'd0);
    chk("arst_state", 32'(fsm_state), 32'(IDLE));
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    chk("post_rst_frm_valid", 32'(frm_valid), 32'd0);
    frame(0, 8'h90, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
